// File: rtl/pixel_row_window.sv
// Expands 64-bit, 8-pixel row beats into 16-pixel filter windows and replicates edge pixels at the row ends.
// Window k is registered when beat k+1 is accepted, and the last window one cycle later; a stalled output slot blocks input.
module pixel_row_window #(
    parameter int ROW_BEATS = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pixels,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_window,
    output logic [CNT_W-1:0] out_col,
    output logic             out_first,
    output logic             out_last
);

    typedef enum logic [1:0] {PRIME, RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROW_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             ONE_BEAT  = (ROW_BEATS == 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        prev_q, prev_d;
    logic [63:0]        cur_q, cur_d;
    logic               out_valid_q, out_valid_d;
    logic [127:0]       out_window_q, out_window_d;
    logic [CNT_W-1:0]   out_col_q, out_col_d;
    logic               out_first_q, out_first_d;
    logic               out_last_q, out_last_d;
    logic               slot_free;
    logic               in_acc;

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        in_ready  = (state_q != FLUSH) && (state_q == PRIME || slot_free) && !reset;
        in_acc    = in_valid && in_ready;

        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        cur_d        = cur_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_window_d = out_window_q;
        out_col_d    = out_col_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;

        case (state_q)
            PRIME: begin
                // The first beat only fills the pipeline; the left pad comes from its pixel 0.
                if (in_acc) begin
                    cur_d   = in_pixels;
                    prev_d  = {8{in_pixels[7:0]}};
                    cnt_d   = CNT_ONE;
                    state_d = ONE_BEAT ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (in_acc) begin
                    out_window_d = {in_pixels[31:0], cur_q, prev_q[63:32]};
                    out_col_d    = cnt_q - CNT_ONE;
                    out_first_d  = (cnt_q == CNT_ONE);
                    out_last_d   = 1'b0;
                    out_valid_d  = 1'b1;
                    prev_d       = cur_q;
                    cur_d        = in_pixels;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            FLUSH: begin
                // No beat follows the last one, so its rightmost pixel supplies the right pad.
                if (slot_free) begin
                    out_window_d = {{4{cur_q[63:56]}}, cur_q, prev_q[63:32]};
                    out_col_d    = LAST_BEAT;
                    out_first_d  = ONE_BEAT;
                    out_last_d   = 1'b1;
                    out_valid_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = PRIME;
                end
            end
            default: begin
                state_d = PRIME;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRIME;
            cnt_q        <= '0;
            prev_q       <= '0;
            cur_q        <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_col_q    <= '0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            out_col_q    <= out_col_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_col    = out_col_q;
    assign out_first  = out_first_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_pixel_row_window.sv
// Bench for pixel_row_window: a scoreboard built from a clamped-column pixel model, plus a single-beat-row instance.
module tb_pixel_row_window;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_first, a_out_last;
    logic [63:0]  a_in_pixels;
    logic [127:0] a_out_window;
    logic [7:0]   a_out_col;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_first, b_out_last;
    logic [63:0]  b_in_pixels;
    logic [127:0] b_out_window;
    logic [7:0]   b_out_col;

    pixel_row_window #(.ROW_BEATS(8), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pixels(a_in_pixels),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_window(a_out_window),
        .out_col(a_out_col), .out_first(a_out_first), .out_last(a_out_last)
    );

    pixel_row_window #(.ROW_BEATS(1), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixels(b_in_pixels),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_window(b_out_window),
        .out_col(b_out_col), .out_first(b_out_first), .out_last(b_out_last)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [127:0] win;
        logic [7:0]   col;
        logic         first;
        logic         last;
    } exp_t;

    exp_t sb[$];

    // Pixel at column c of a row is base+c; columns outside the row clamp to the edge.
    function automatic logic [127:0] exp_win(input logic [7:0] base, input int k, input int rb);
        logic [127:0] w;
        int c;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            c = 8 * k - 4 + i;
            if (c < 0) c = 0;
            if (c > 8 * rb - 1) c = 8 * rb - 1;
            w[8*i +: 8] = base + 8'(c);
        end
        return w;
    endfunction

    function automatic logic [63:0] beat(input logic [7:0] base, input int k);
        logic [63:0] d;
        for (int n = 0; n < 8; n++) d[8*n +: 8] = base + 8'(8 * k + n);
        return d;
    endfunction

    // out_ready driver: 0 = always 1, 1 = pattern 1,0,0,1, 2 = held 0
    int         rdy_mode = 0;
    logic [1:0] rdy_phase;
    logic [3:0] rdy_pat;

    initial begin
        a_out_ready = 1'b0;
        rdy_phase   = 2'd0;
        rdy_pat     = 4'b1001;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: a_out_ready = 1'b1;
                1: begin
                    a_out_ready = rdy_pat[rdy_phase];
                    rdy_phase   = rdy_phase + 2'd1;
                end
                default: a_out_ready = 1'b0;
            endcase
        end
    end

    int           acc_cnt = 0;
    int           win_cnt = 0;
    logic         hold_pend;
    logic [127:0] hold_win;
    logic [7:0]   hold_col;
    exp_t         e;

    initial begin
        hold_pend = 1'b0;
        hold_win  = '0;
        hold_col  = '0;
        forever begin
            @(negedge clk);
            if (hold_pend) begin
                chk("hold_valid", 128'(a_out_valid), 128'd1);
                chk("hold_window", a_out_window, hold_win);
                chk("hold_col", 128'(a_out_col), 128'(hold_col));
            end
            hold_pend = a_out_valid && !a_out_ready && !reset;
            hold_win  = a_out_window;
            hold_col  = a_out_col;
            if (!reset && a_in_valid && a_in_ready) acc_cnt++;
            if (!reset && a_out_valid && a_out_ready) begin
                chk("sb_nonempty", 128'(sb.size() > 0), 128'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("win", a_out_window, e.win);
                    chk("col", 128'(a_out_col), 128'(e.col));
                    chk("first", 128'(a_out_first), 128'(e.first));
                    chk("last", 128'(a_out_last), 128'(e.last));
                end
                if (win_cnt == 0) chk("first_win_const", a_out_window, 128'h0B0A0908_07060504_03020100_00000000);
                if (win_cnt == 7) chk("last_win_const", a_out_window, 128'h3F3F3F3F_3F3E3D3C_3B3A3938_37363534);
                win_cnt++;
            end
        end
    end

    task automatic send_beat(input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        a_in_valid  = 1'b1;
        a_in_pixels = d;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 128'(a_in_ready), 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [7:0] base, input int nb);
        for (int k = 0; k < 8; k++) sb.push_back('{exp_win(base, k, 8), 8'(k), (k == 0), (k == 7)});
        for (int k = 0; k < nb; k++) send_beat(beat(base, k));
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    int acc_base;

    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0;
        a_in_pixels = '0;
        b_in_valid  = 1'b0;
        b_in_pixels = '0;
        b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 128'(a_out_valid), 128'd0);
        chk("rst_out_window", a_out_window, 128'd0);
        chk("rst_out_col", 128'(a_out_col), 128'd0);
        chk("rst_in_ready", 128'(a_in_ready), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(a_in_ready), 128'd1);
        @(posedge clk);
        #1;

        // single-beat row
        b_in_pixels = 64'h8877665544332211;
        b_in_valid  = 1'b1;
        b_out_ready = 1'b1;
        @(negedge clk);
        chk("b_in_ready", 128'(b_in_ready), 128'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_flush_in_ready", 128'(b_in_ready), 128'd0);
        chk("b_flush_no_out", 128'(b_out_valid), 128'd0);
        @(negedge clk);
        chk("b_out_valid", 128'(b_out_valid), 128'd1);
        chk("b_window", b_out_window, 128'h88888888_88776655_44332211_11111111);
        chk("b_col", 128'(b_out_col), 128'd0);
        chk("b_first", 128'(b_out_first), 128'd1);
        chk("b_last", 128'(b_out_last), 128'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b_out_gone", 128'(b_out_valid), 128'd0);
        @(posedge clk);
        #1;

        // row with no backpressure
        rdy_mode = 0;
        send_row(8'h00, 8);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 128'(a_in_ready), 128'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("prime_in_ready", 128'(a_in_ready), 128'd1);
        drain();

        // same row under a 1,0,0,1 out_ready pattern
        rdy_mode = 1;
        acc_base = acc_cnt;
        send_row(8'h00, 8);
        a_in_valid = 1'b0;
        drain();
        chk("accepts_per_row", 128'(acc_cnt - acc_base), 128'd8);
        rdy_mode = 0;

        // back-to-back rows, in_valid held through the flush cycle
        send_row(8'h40, 8);
        a_in_pixels = beat(8'hA0, 0);
        @(negedge clk);
        chk("flush_hold_in_ready", 128'(a_in_ready), 128'd0);
        @(posedge clk);
        #1;
        send_row(8'hA0, 8);
        a_in_valid = 1'b0;
        drain();

        // reset mid-row with a window pending
        send_row(8'h20, 3);
        a_in_valid = 1'b0;
        rdy_mode   = 2;
        @(negedge clk);
        chk("pend_before_reset", 128'(a_out_valid), 128'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("reset_out_valid", 128'(a_out_valid), 128'd0);
        chk("reset_in_ready", 128'(a_in_ready), 128'd1);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_row(8'h60, 8);
        a_in_valid = 1'b0;
        drain();

        chk("sb_final", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
